esm_dwell_reporter: RTL and testbench
=====================================

# esm_dwell_reporter

Downstream consumer of `esm_dwell_controller`; produces one report per completed dwell.
- Latches the dwell metadata when a dwell starts.
- While the dwell is active, counts active cycles and detected pulses.
- When the dwell ends, emits a fixed 6-word AXI-stream report for the status/DMA path.
- Dwells that start while a report is still being sent are counted as dropped and reported in the next report.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32: report word width; only 32 is supported.
- `REPORT_MAGIC`, 32'h45534D52: value of report word 0.

Ports:
- `Clk`  in  1: system clock.
- `Rst`  in  1: reset, asynchronous, active-high.
- `Dwell_active`  in  1: high for the whole dwell (from `esm_dwell_controller`).
- `Dwell_data`  in  `esm_dwell_metadata_t`: dwell metadata, valid whenever `Dwell_active` is high.
- `Pulse_valid`  in  1: one-cycle strobe per detected pulse.
- `Axis_ready`  in  1: downstream ready.
- `Axis_valid`  out  1: report beat valid.
- `Axis_data`  out  32: report word.
- `Axis_last`  out  1: high on word 5 only.

## Operation
- `r_dwell_active` is `Dwell_active` delayed by one clock, registered in every state. A rising edge is a cycle with `Dwell_active`=1 and `r_dwell_active`=0.
- State machine: IDLE, ACTIVE, REPORT.
- IDLE
  - On a rising edge: latch `tag`, `frequency` and `duration` from `Dwell_data`.
  - Set cycle_count=1.
  - Set pulse_count to `Pulse_valid` of that same cycle.
  - Go to ACTIVE.
  - `Dwell_active` already high on return to IDLE without a new rising edge: ignored.
- ACTIVE
  - Each cycle with `Dwell_active`=1: cycle_count += 1, and pulse_count += `Pulse_valid`.
  - First cycle with `Dwell_active`=0:
    - Snapshot drop_count into drop_snap and clear drop_count.
    - Load beat index 0 and go to REPORT.
    - `Pulse_valid` in this cycle is ignored.
- REPORT
  - Present words 0..5 in order.
  - Advance one word on each cycle with `Axis_valid`&&`Axis_ready`.
  - On acceptance of word 5: seq_num += 1 (32-bit, wraps), go to IDLE.
- Report words:
  - w0 = `REPORT_MAGIC`
  - w1 = seq_num
  - w2 = {tag[15:0], frequency[15:0]}
  - w3 = latched duration[31:0]
  - w4 = cycle_count[31:0]
  - w5 = {pulse_count[23:0], drop_snap[7:0]}
- Dropped dwells: a rising edge seen in REPORT increments drop_count, including in the same cycle as word-5 acceptance. Drops during REPORT are reported in the next report, not the current one.
- Arithmetic: cycle_count, pulse_count and drop_count saturate at all-ones (32, 24 and 8 bits); they never wrap.
- `Pulse_valid` outside IDLE-rising-edge/ACTIVE cycles with `Dwell_active`=1 is ignored.
- Reset mid-operation:
  - All state is cleared asynchronously and any partial report is abandoned, with no `Axis_last`.
  - seq_num and drop_count also clear.
  - If `Dwell_active` is high when `Rst` falls, `r_dwell_active` is 0, so the first post-reset cycle counts as a rising edge.

## Timing
- Reset values: `Axis_valid`=0, `Axis_last`=0, `Axis_data`=0, state=IDLE, `r_dwell_active`=0, seq_num=0, all counters 0.
- Latency: `Axis_valid` rises on the clock edge that samples the first `Dwell_active`=0 cycle, i.e. the cycle immediately after it.
- Minimum report duration is 6 cycles with `Axis_ready` held high.
- Outputs are registered. Once `Axis_valid` is high, `Axis_data` and `Axis_last` hold steady until accepted. `Axis_valid` stays high through backpressure and never drops mid-report.
- `Axis_valid` drops the cycle after word 5 is accepted.
- If a new rising edge occurs in that cycle, it is sampled in IDLE and starts a new dwell.
- Back-to-back dwells:
  - A dwell whose rising edge is at least 1 cycle after word-5 acceptance is reported normally.
  - An edge on or before that cycle is dropped.
- A 1-cycle dwell (high for exactly 1 cycle) reports w4=1.

## Test plan
- Reset, then a 100-cycle dwell with tag=0x1234, freq=0x5678, duration=100 and 7 `Pulse_valid` strobes, `Ready`=1 → 6 consecutive beats: 0x45534D52, 0, 0x12345678, 100, 100, 0x00000700; `Axis_last` only on beat 5.
- Same dwell with `Ready` toggling 1 cycle on / 2 cycles off → identical words, each held stable while stalled, seq_num=0; a second dwell → w1=1.
- During the report with `Ready`=0, pulse `Dwell_active` twice, then run a normal 10-cycle dwell → the first report has w5[7:0]=0. The pulses start during REPORT, so they are never themselves reported and only raise drop_count. The next report has w4=10 and w5[7:0]=2.
- 5 `Pulse_valid` strobes while idle, then a 1-cycle dwell with `Pulse_valid`=1 → w4=1, w5=0x00000100.
- Assert `Rst` while word 3 is stalled → `Axis_valid`=0 immediately. The next dwell's report has w1=0 and w5[7:0]=0.
- Rising edge in the exact cycle word 5 is accepted → no report for it. The following report has drop field 1.

Source files
------------

// File: rtl/esm_dwell_reporter_if.sv
`default_nettype none
// ============================================================================
// Module   : esm_dwell_reporter_if
// Purpose  : Dwell-side inputs and AXI-stream report outputs of the dwell
//            reporter, bundled with master (driver) / slave (reporter) views.
// Revision : 1.0 - initial release
// ============================================================================
interface esm_dwell_reporter_if #(
  parameter int AXI_DATA_WIDTH = 32
);

  // Dwell metadata as delivered by the dwell controller.
  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] frequency;
    logic [31:0] duration;
  } esm_dwell_metadata_t;

  logic                      Dwell_active;
  esm_dwell_metadata_t       Dwell_data;
  logic                      Pulse_valid;
  logic                      Axis_ready;
  logic                      Axis_valid;
  logic [AXI_DATA_WIDTH-1:0] Axis_data;
  logic                      Axis_last;

  // Upstream/downstream environment side.
  modport master (
    output Dwell_active, Dwell_data, Pulse_valid, Axis_ready,
    input  Axis_valid, Axis_data, Axis_last
  );

  // Reporter side.
  modport slave (
    input  Dwell_active, Dwell_data, Pulse_valid, Axis_ready,
    output Axis_valid, Axis_data, Axis_last
  );

endinterface
`default_nettype wire

// File: rtl/esm_dwell_reporter.sv
`default_nettype none
// ============================================================================
// Module   : esm_dwell_reporter
// Purpose  : Measures each dwell (active cycles, pulses) and emits a fixed
//            6-word AXI-stream report when the dwell ends. Dwells starting
//            while a report is in flight are counted as dropped and carried
//            into the following report.
// Revision : 1.0 - initial release
// ============================================================================
module esm_dwell_reporter #(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [31:0] REPORT_MAGIC   = 32'h45534D52
) (
  input wire                  Clk,
  input wire                  Rst,
  esm_dwell_reporter_if.slave bus
);

  localparam logic [1:0]  c_ST_IDLE   = 2'd0;
  localparam logic [1:0]  c_ST_ACTIVE = 2'd1;
  localparam logic [1:0]  c_ST_REPORT = 2'd2;
  localparam logic [2:0]  c_LAST_BEAT = 3'd5;
  localparam logic [31:0] c_CYCLE_MAX = 32'hFFFF_FFFF;
  localparam logic [23:0] c_PULSE_MAX = 24'hFF_FFFF;
  localparam logic [7:0]  c_DROP_MAX  = 8'hFF;

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic                      r_dwell_active;
  logic [15:0]               r_tag;
  logic [15:0]               r_frequency;
  logic [31:0]               r_duration;
  logic [31:0]               r_cycle_count;
  logic [23:0]               r_pulse_count;
  logic [7:0]                r_drop_count;
  logic [7:0]                r_drop_snap;
  logic [31:0]               r_seq_num;
  logic [2:0]                r_beat;
  logic                      r_axis_valid;
  logic                      r_axis_last;
  logic [AXI_DATA_WIDTH-1:0] r_axis_data;

  logic                      w_rise;
  logic                      w_accept;
  logic                      w_last_accept;
  logic [2:0]                w_beat_inc;
  logic [31:0]               w_word;
  logic [2:0]                w_beat_nxt;
  logic                      w_valid_nxt;
  logic                      w_last_nxt;
  logic [AXI_DATA_WIDTH-1:0] w_data_nxt;

  assign w_rise        = bus.Dwell_active & ~r_dwell_active;
  assign w_accept      = r_axis_valid & bus.Axis_ready;
  assign w_last_accept = w_accept && (r_beat == c_LAST_BEAT);
  assign w_beat_inc    = r_beat + 3'd1;

  assign bus.Axis_valid = r_axis_valid;
  assign bus.Axis_last  = r_axis_last;
  assign bus.Axis_data  = r_axis_data;

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin : p_state_reg
    if (Rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: a dwell runs IDLE -> ACTIVE -> REPORT -> IDLE.
  always_comb begin : p_next_state
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_rise) w_state_nxt = c_ST_ACTIVE;
      c_ST_ACTIVE: if (!bus.Dwell_active) w_state_nxt = c_ST_REPORT;
      c_ST_REPORT: if (w_last_accept) w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Word that follows the current beat; all fields are frozen during REPORT.
  always_comb begin : p_word_sel
    w_word = REPORT_MAGIC;
    case (w_beat_inc)
      3'd1:    w_word = r_seq_num;
      3'd2:    w_word = {r_tag, r_frequency};
      3'd3:    w_word = r_duration;
      3'd4:    w_word = r_cycle_count;
      3'd5:    w_word = {r_pulse_count, r_drop_snap};
      default: w_word = REPORT_MAGIC;
    endcase
  end

  // Output decode: start the report on dwell end, step a beat per acceptance.
  always_comb begin : p_output_comb
    w_valid_nxt = r_axis_valid;
    w_last_nxt  = r_axis_last;
    w_data_nxt  = r_axis_data;
    w_beat_nxt  = r_beat;
    case (r_state)
      c_ST_ACTIVE: begin
        if (!bus.Dwell_active) begin
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_data_nxt  = REPORT_MAGIC;
          w_beat_nxt  = 3'd0;
        end
      end
      c_ST_REPORT: begin
        if (w_last_accept) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_data_nxt  = '0;
          w_beat_nxt  = 3'd0;
        end else if (w_accept) begin
          w_beat_nxt  = w_beat_inc;
          w_data_nxt  = w_word;
          w_last_nxt  = (w_beat_inc == c_LAST_BEAT);
        end
      end
      default: ;
    endcase
  end

  // Registered stream outputs and beat index.
  always_ff @(posedge Clk or posedge Rst) begin : p_output_reg
    if (Rst) begin
      r_axis_valid <= 1'b0;
      r_axis_last  <= 1'b0;
      r_axis_data  <= '0;
      r_beat       <= 3'd0;
    end else begin
      r_axis_valid <= w_valid_nxt;
      r_axis_last  <= w_last_nxt;
      r_axis_data  <= w_data_nxt;
      r_beat       <= w_beat_nxt;
    end
  end

  // Dwell measurement, drop accounting and sequence numbering.
  always_ff @(posedge Clk or posedge Rst) begin : p_datapath
    if (Rst) begin
      r_dwell_active <= 1'b0;
      r_tag          <= '0;
      r_frequency    <= '0;
      r_duration     <= '0;
      r_cycle_count  <= '0;
      r_pulse_count  <= '0;
      r_drop_count   <= '0;
      r_drop_snap    <= '0;
      r_seq_num      <= '0;
    end else begin
      r_dwell_active <= bus.Dwell_active;
      case (r_state)
        c_ST_IDLE: begin
          if (w_rise) begin
            r_tag         <= bus.Dwell_data.tag;
            r_frequency   <= bus.Dwell_data.frequency;
            r_duration    <= bus.Dwell_data.duration;
            r_cycle_count <= 32'd1;
            r_pulse_count <= {23'd0, bus.Pulse_valid};
          end
        end
        c_ST_ACTIVE: begin
          if (bus.Dwell_active) begin
            if (r_cycle_count != c_CYCLE_MAX) r_cycle_count <= r_cycle_count + 32'd1;
            if (bus.Pulse_valid && (r_pulse_count != c_PULSE_MAX))
              r_pulse_count <= r_pulse_count + 24'd1;
          end else begin
            // Drops seen so far belong to this report; new ones go to the next.
            r_drop_snap  <= r_drop_count;
            r_drop_count <= 8'd0;
          end
        end
        c_ST_REPORT: begin
          if (w_rise && (r_drop_count != c_DROP_MAX)) r_drop_count <= r_drop_count + 8'd1;
          if (w_last_accept) r_seq_num <= r_seq_num + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_esm_dwell_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_esm_dwell_reporter
// Purpose  : Self-checking bench for esm_dwell_reporter. Dwells, drop pulses
//            and backpressure are generated at scenario level; expected
//            reports come from a dwell-level model (sequence number, pending
//            drops, per-dwell length and strobe count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_esm_dwell_reporter;

  localparam logic [31:0] MAGIC = 32'h45534D52;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  esm_dwell_reporter_if #(.AXI_DATA_WIDTH(32)) bus ();

  esm_dwell_reporter #(
    .AXI_DATA_WIDTH(32),
    .REPORT_MAGIC  (MAGIC)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Dwell-level reference model state.
  logic [31:0] m_seq;
  int          m_drops;

  // Description of the most recent dwell as driven.
  logic [15:0] d_tag;
  logic [15:0] d_freq;
  logic [31:0] d_dur;
  int          d_len;
  int          d_pulses;

  logic [31:0] exp_w [6];
  logic [31:0] got_w [6];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Quiet period: dwell low, random ignored strobes (first 'strobes' forced).
  task automatic idle_gap(input int n, input int strobes);
    for (int i = 0; i < n; i++) begin
      bus.Dwell_active = 1'b0;
      bus.Pulse_valid  = (i < strobes) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.Axis_ready   = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    check_val("idle_quiet", 32'(bus.Axis_valid), 32'd0);
  endtask

  // Hold Dwell_active high for len cycles. Metadata is only valid on the first
  // cycle as far as the report is concerned; later cycles carry noise.
  task automatic run_dwell(input logic [15:0] tag, input logic [15:0] freq,
                           input logic [31:0] dur, input int len, input int pmode);
    logic pv;
    d_tag = tag; d_freq = freq; d_dur = dur; d_len = len; d_pulses = 0;
    for (int i = 0; i < len; i++) begin
      bus.Dwell_active = 1'b1;
      if (i == 0) bus.Dwell_data = {tag, freq, dur};
      else        bus.Dwell_data = {32'($urandom), 32'($urandom)};
      case (pmode)
        1:       pv = ((i % 15) == 1);
        2:       pv = ($urandom_range(0, 3) == 0);
        3:       pv = 1'b1;
        default: pv = 1'b0;
      endcase
      bus.Pulse_valid = pv;
      if (pv) d_pulses++;
      bus.Axis_ready = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    check_val("quiet_during_dwell", 32'(bus.Axis_valid), 32'd0);
    bus.Dwell_active = 1'b0;
    bus.Dwell_data   = {32'($urandom), 32'($urandom)};
    bus.Pulse_valid  = 1'b1;
  endtask

  // Receive one report. rmode: 0 ready high, 1 one-on/two-off, 2 random.
  // Drop pulses are injected while the report is in flight; abort_at<6 stops
  // with the given beat stalled (used before a reset).
  task automatic collect_report(input int rmode, input int n_drops, input bit stall_drops,
                                input bit drop_on_last, input int abort_at);
    int   beat     = 0;
    int   cyc      = 0;
    int   left     = n_drops;
    int   injected = 0;
    bit   done     = 1'b0;
    logic r;
    exp_w[0] = MAGIC;
    exp_w[1] = m_seq;
    exp_w[2] = {d_tag, d_freq};
    exp_w[3] = d_dur;
    exp_w[4] = 32'(d_len);
    exp_w[5] = {d_pulses[23:0], m_drops[7:0]};
    m_drops  = 0;
    @(negedge Clk);
    check_val("valid_latency", 32'(bus.Axis_valid), 32'd1);
    while (!done && cyc < 3000) begin
      if (bus.Axis_valid !== 1'b1) begin
        check_val("valid_held", 32'(bus.Axis_valid), 32'd1);
        break;
      end
      check_val($sformatf("w%0d", beat), bus.Axis_data, exp_w[beat]);
      check_val($sformatf("last%0d", beat), 32'(bus.Axis_last), 32'(beat == 5));
      if (beat == abort_at) begin
        bus.Axis_ready = 1'b0;
        break;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = ((cyc % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (stall_drops && left > 0) r = 1'b0;
      if (bus.Dwell_active) begin
        bus.Dwell_active = 1'b0;
        if (drop_on_last && beat == 5) r = 1'b0;
      end else if (drop_on_last && beat == 5) begin
        bus.Dwell_active = 1'b1;
        injected++;
        r = 1'b1;
      end else if (left > 0) begin
        bus.Dwell_active = 1'b1;
        left--;
        injected++;
      end
      bus.Pulse_valid = 1'($urandom_range(0, 1));
      bus.Axis_ready  = r;
      if (r) begin
        got_w[beat] = bus.Axis_data;
        if (beat == 5) done = 1'b1;
        beat++;
      end
      @(negedge Clk);
      cyc++;
    end
    if (abort_at > 5) begin
      check_val("report_beats", 32'(beat), 32'd6);
      check_val("valid_drop", 32'(bus.Axis_valid), 32'd0);
      bus.Dwell_active = 1'b0;
      bus.Axis_ready   = 1'b0;
      m_seq   = m_seq + 32'd1;
      m_drops = (injected > 255) ? 255 : injected;
    end
  endtask

  initial begin
    bus.Dwell_active = 1'b0;
    bus.Dwell_data   = '0;
    bus.Pulse_valid  = 1'b0;
    bus.Axis_ready   = 1'b0;
    m_seq   = 32'd0;
    m_drops = 0;
    Rst     = 1'b1;
    repeat (3) @(negedge Clk);
    check_val("rst_valid", 32'(bus.Axis_valid), 32'd0);
    check_val("rst_last",  32'(bus.Axis_last),  32'd0);
    check_val("rst_data",  bus.Axis_data,       32'd0);
    Rst = 1'b0;
    idle_gap(3, 0);

    // Reference dwell with full-rate ready.
    run_dwell(16'h1234, 16'h5678, 32'd100, 100, 1);
    collect_report(0, 0, 1'b0, 1'b0, 6);
    check_val("t1_w0", got_w[0], 32'h45534D52);
    check_val("t1_w1", got_w[1], 32'd0);
    check_val("t1_w2", got_w[2], 32'h12345678);
    check_val("t1_w3", got_w[3], 32'd100);
    check_val("t1_w4", got_w[4], 32'd100);
    check_val("t1_w5", got_w[5], 32'h00000700);

    // Same dwell under 1-on/2-off backpressure.
    idle_gap(2, 0);
    run_dwell(16'h1234, 16'h5678, 32'd100, 100, 1);
    collect_report(1, 0, 1'b0, 1'b0, 6);
    check_val("t2_seq", got_w[1], 32'd1);
    check_val("t2_w5",  got_w[5], 32'h00000700);

    // Two dwells dropped while the report is stalled.
    idle_gap(2, 0);
    run_dwell(16'hA0A0, 16'h0B0B, 32'd20, 20, 2);
    collect_report(2, 2, 1'b1, 1'b0, 6);
    check_val("t3_first_drop", {24'd0, got_w[5][7:0]}, 32'd0);
    idle_gap(3, 0);
    run_dwell(16'h0C0C, 16'h0D0D, 32'd10, 10, 2);
    collect_report(0, 0, 1'b0, 1'b0, 6);
    check_val("t3_w4",   got_w[4], 32'd10);
    check_val("t3_drop", {24'd0, got_w[5][7:0]}, 32'd2);

    // Idle strobes ignored, then a 1-cycle dwell with a strobe.
    idle_gap(6, 5);
    run_dwell(16'h0001, 16'h0002, 32'd1, 1, 3);
    collect_report(2, 0, 1'b0, 1'b0, 6);
    check_val("t4_w4", got_w[4], 32'd1);
    check_val("t4_w5", got_w[5], 32'h00000100);

    // Rising edge in the cycle word 5 is accepted.
    idle_gap(2, 0);
    run_dwell(16'h1111, 16'h2222, 32'd5, 5, 2);
    collect_report(0, 0, 1'b0, 1'b1, 6);
    idle_gap(2, 0);
    run_dwell(16'h3333, 16'h4444, 32'd3, 3, 0);
    collect_report(0, 0, 1'b0, 1'b0, 6);
    check_val("t5_drop", {24'd0, got_w[5][7:0]}, 32'd1);

    // Drop counter saturation.
    idle_gap(2, 0);
    run_dwell(16'h5555, 16'h6666, 32'd4, 4, 2);
    collect_report(0, 300, 1'b1, 1'b0, 6);
    idle_gap(2, 0);
    run_dwell(16'h7777, 16'h8888, 32'd6, 6, 2);
    collect_report(2, 0, 1'b0, 1'b0, 6);
    check_val("t6_drop_sat", {24'd0, got_w[5][7:0]}, 32'd255);

    // Randomized dwells, backpressure and drops.
    for (int k = 0; k < 25; k++) begin
      idle_gap($urandom_range(1, 4), 0);
      run_dwell(16'($urandom), 16'($urandom), 32'($urandom), $urandom_range(1, 40), 2);
      collect_report(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 6);
    end

    // Reset while word 3 is stalled, with drops pending and Dwell_active high.
    idle_gap(2, 0);
    run_dwell(16'h9999, 16'hAAAA, 32'd8, 8, 2);
    collect_report(0, 2, 1'b0, 1'b0, 3);
    #2;
    Rst = 1'b1;
    #1;
    check_val("rst_async_valid", 32'(bus.Axis_valid), 32'd0);
    check_val("rst_async_last",  32'(bus.Axis_last),  32'd0);
    bus.Dwell_active = 1'b1;
    bus.Dwell_data   = {16'hBEEF, 16'h0042, 32'd77};
    bus.Pulse_valid  = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst     = 1'b0;
    m_seq   = 32'd0;
    m_drops = 0;
    run_dwell(16'hBEEF, 16'h0042, 32'd77, 12, 2);
    collect_report(2, 0, 1'b0, 1'b0, 6);
    check_val("t7_seq",  got_w[1], 32'd0);
    check_val("t7_drop", {24'd0, got_w[5][7:0]}, 32'd0);
    check_val("t7_w4",   got_w[4], 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
